vram_arbiter: RTL and testbench

Single-port VRAM access scheduler inside `xosera_main`. It shares the one 16-bit VRAM between three requesters: video fetch, host register interface (SPI/bus), and blitter. Video fetch has absolute priority; host and blitter alternate round-robin. All requests are registered into a fixed-latency pipeline so every requester sees the same timing.

---
 rtl/vram_arbiter.sv | 116 +++++++++++
 tb/tb_vram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM scheduler: video has absolute priority, host and blitter share the rest round-robin.
// Decide on cycle N, issue on N+1, read data back on N+2 for every requester alike.
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rd_valid,

    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic              host_rd_valid,

    input  logic              blit_req,
    input  logic              blit_wr,
    input  logic [ADDR_W-1:0] blit_addr,
    input  logic [DATA_W-1:0] blit_data,
    output logic              blit_gnt,
    output logic              blit_rd_valid,

    output logic [DATA_W-1:0] rd_data,

    output logic              vram_sel,
    output logic              vram_wr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i
);

    localparam logic RR_HOST = 1'b0;
    localparam logic RR_BLIT = 1'b1;

    logic rr_last;
    logic elig_vid, elig_host, elig_blit;
    logic win_vid, win_host, win_blit;
    logic rd_ret;

    // A requester holding gnt is still showing the access just issued, so it sits out this cycle.
    assign elig_vid  = vid_req  & ~vid_gnt;
    assign elig_host = host_req & ~host_gnt;
    assign elig_blit = blit_req & ~blit_gnt;

    always_comb begin
        win_vid  = elig_vid;
        win_host = 1'b0;
        win_blit = 1'b0;
        if (!elig_vid) begin
            if (elig_host && elig_blit) begin
                win_host = (rr_last == RR_BLIT);
                win_blit = (rr_last == RR_HOST);
            end else begin
                win_host = elig_host;
                win_blit = elig_blit;
            end
        end
    end

    assign rd_ret = vram_sel & ~vram_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last       <= RR_BLIT;
            vid_gnt       <= 1'b0;
            host_gnt      <= 1'b0;
            blit_gnt      <= 1'b0;
            vram_sel      <= 1'b0;
            vram_wr       <= 1'b0;
            vram_addr     <= '0;
            vram_data_o   <= '0;
            vid_rd_valid  <= 1'b0;
            host_rd_valid <= 1'b0;
            blit_rd_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            vid_gnt  <= win_vid;
            host_gnt <= win_host;
            blit_gnt <= win_blit;
            vram_sel <= win_vid | win_host | win_blit;
            vram_wr  <= (win_host & host_wr) | (win_blit & blit_wr);

            // Address/data hold their last values when the bus is idle; video never touches write data.
            if (win_vid) begin
                vram_addr <= vid_addr;
            end else if (win_host) begin
                vram_addr   <= host_addr;
                vram_data_o <= host_data;
            end else if (win_blit) begin
                vram_addr   <= blit_addr;
                vram_data_o <= blit_data;
            end

            if (win_host) begin
                rr_last <= RR_HOST;
            end else if (win_blit) begin
                rr_last <= RR_BLIT;
            end

            // The gnt register doubles as the owner tag for the access currently on the bus.
            vid_rd_valid  <= vid_gnt  & rd_ret;
            host_rd_valid <= host_gnt & rd_ret;
            blit_rd_valid <= blit_gnt & rd_ret;
            if (rd_ret) begin
                rd_data <= vram_data_i;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: per-requester op queues drive the ports, a transaction-level model
// predicts grants, bus contents and read returns, and a simple VRAM array answers the bus.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_req = 1'b0, host_req = 1'b0, blit_req = 1'b0;
    logic        host_wr = 1'b0, blit_wr = 1'b0;
    logic [15:0] vid_addr = '0, host_addr = '0, blit_addr = '0;
    logic [15:0] host_data = '0, blit_data = '0;
    logic        vid_gnt, host_gnt, blit_gnt;
    logic        vid_rd_valid, host_rd_valid, blit_rd_valid;
    logic [15:0] rd_data;
    logic        vram_sel, vram_wr;
    logic [15:0] vram_addr, vram_data_o, vram_data_i;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rd_valid(vid_rd_valid),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
        .host_gnt(host_gnt), .host_rd_valid(host_rd_valid),
        .blit_req(blit_req), .blit_wr(blit_wr), .blit_addr(blit_addr), .blit_data(blit_data),
        .blit_gnt(blit_gnt), .blit_rd_valid(blit_rd_valid),
        .rd_data(rd_data),
        .vram_sel(vram_sel), .vram_wr(vram_wr), .vram_addr(vram_addr),
        .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    // Requester index: 0 video, 1 host, 2 blitter.
    op_t        q [3][$];
    logic [2:0] popnext = '0;

    logic [15:0] vmem    [0:65535];
    logic [15:0] ref_mem [0:65535];
    assign vram_data_i = vram_sel ? vmem[vram_addr] : 16'h0000;

    logic [2:0]  m_gnt = '0, m_rdv = '0;
    logic        m_sel = 1'b0, m_wr = 1'b0;
    logic [15:0] m_addr = '0, m_data = '0, m_rd_data = '0;
    int          m_last = 2;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present the head of each queue; an op is retired the cycle after its grant.
    task automatic drive();
        for (int r = 0; r < 3; r++) begin
            if (m_gnt[r]) popnext[r] = 1'b1;
            else if (popnext[r]) begin
                if (q[r].size() > 0) void'(q[r].pop_front());
                popnext[r] = 1'b0;
            end
        end
        if (q[0].size() > 0) begin vid_req = 1'b1; vid_addr = q[0][0].addr; end
        else begin vid_req = 1'b0; vid_addr = 16'($urandom); end
        if (q[1].size() > 0) begin
            host_req = 1'b1; host_wr = q[1][0].wr; host_addr = q[1][0].addr; host_data = q[1][0].data;
        end else begin
            host_req = 1'b0; host_wr = 1'($urandom); host_addr = 16'($urandom); host_data = 16'($urandom);
        end
        if (q[2].size() > 0) begin
            blit_req = 1'b1; blit_wr = q[2][0].wr; blit_addr = q[2][0].addr; blit_data = q[2][0].data;
        end else begin
            blit_req = 1'b0; blit_wr = 1'($urandom); blit_addr = 16'($urandom); blit_data = 16'($urandom);
        end
    endtask

    // One clock: predict from the inputs seen before the edge, then compare after it.
    task automatic step();
        logic [2:0]  req, el;
        logic        rst, d_sel, d_wr;
        logic [15:0] d_addr, d_data;
        op_t         ops [3];
        int          win;
        req    = {blit_req, host_req, vid_req};
        rst    = reset;
        ops[0] = '{1'b0, vid_addr, 16'h0000};
        ops[1] = '{host_wr, host_addr, host_data};
        ops[2] = '{blit_wr, blit_addr, blit_data};
        d_sel  = vram_sel; d_wr = vram_wr; d_addr = vram_addr; d_data = vram_data_o;
        el  = req & ~m_gnt;
        win = -1;
        if (el[0]) win = 0;
        else if (el[1] && el[2]) win = (m_last == 2) ? 1 : 2;
        else if (el[1]) win = 1;
        else if (el[2]) win = 2;

        @(posedge clk);
        #1;
        if (d_sel && d_wr) vmem[d_addr] = d_data;

        m_rdv = (m_sel && !m_wr) ? m_gnt : 3'b000;
        if (m_sel && !m_wr) m_rd_data = ref_mem[m_addr];
        if (m_sel && m_wr)  ref_mem[m_addr] = m_data;
        m_gnt = '0; m_sel = 1'b0; m_wr = 1'b0;
        if (win >= 0) begin
            m_gnt[win] = 1'b1;
            m_sel      = 1'b1;
            m_addr     = ops[win].addr;
            if (win > 0) begin
                m_wr   = ops[win].wr;
                m_data = ops[win].data;
                m_last = win;
            end
        end
        if (rst) begin
            m_gnt = '0; m_rdv = '0; m_sel = 1'b0; m_wr = 1'b0;
            m_addr = '0; m_data = '0; m_rd_data = '0; m_last = 2;
        end

        chk("gnt", {29'd0, blit_gnt, host_gnt, vid_gnt}, {29'd0, m_gnt});
        chk("rd_valid", {29'd0, blit_rd_valid, host_rd_valid, vid_rd_valid}, {29'd0, m_rdv});
        chk("vram_sel", {31'd0, vram_sel}, {31'd0, m_sel});
        chk("vram_wr", {31'd0, vram_wr}, {31'd0, m_wr});
        chk("vram_addr", {16'd0, vram_addr}, {16'd0, m_addr});
        if (m_sel && m_wr) chk("vram_data_o", {16'd0, vram_data_o}, {16'd0, m_data});
        if (m_rdv != 3'b000) chk("rd_data", {16'd0, rd_data}, {16'd0, m_rd_data});
    endtask

    task automatic cycle();
        drive();
        step();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain", {31'd0, (q[0].size() + q[1].size() + q[2].size()) == 0}, 32'd1);
        repeat (3) cycle();
    endtask

    task automatic push(input int r, input logic wr, input logic [15:0] addr, input logic [15:0] data);
        op_t o;
        o = '{(r == 0) ? 1'b0 : wr, addr, data};
        q[r].push_back(o);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            vmem[a]    = a[15:0] ^ 16'hACDB;
            ref_mem[a] = a[15:0] ^ 16'hACDB;
        end

        // Reset values
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_data_o", {16'd0, vram_data_o}, 32'd0);

        // Single host read at 0x1234
        push(1, 1'b0, 16'h1234, 16'h0000);
        cycle();
        chk("hrd_gnt", {31'd0, host_gnt}, 32'd1);
        chk("hrd_addr", {16'd0, vram_addr}, 32'h1234);
        chk("hrd_wr", {31'd0, vram_wr}, 32'd0);
        cycle();
        chk("hrd_valid", {31'd0, host_rd_valid}, 32'd1);
        chk("hrd_data", {16'd0, rd_data}, 32'hBEEF);
        repeat (2) cycle();

        // Host/blit write contention after reset alternates starting with host
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
            push(2, 1'b1, 16'h0200 + 16'(i), 16'hB000 + 16'(i));
        end
        cycle();
        chk("rr_first", {30'd0, blit_gnt, host_gnt}, 32'b01);
        cycle();
        chk("rr_second", {30'd0, blit_gnt, host_gnt}, 32'b10);
        run_until_idle(100);

        // Video held continuously against host
        for (int i = 0; i < 6; i++) push(0, 1'b0, 16'h3000 + 16'(i), 16'h0);
        for (int i = 0; i < 3; i++) push(1, 1'b0, 16'h0100 + 16'(i), 16'h0);
        run_until_idle(100);

        // All three request together
        push(0, 1'b0, 16'h4000, 16'h0);
        push(1, 1'b0, 16'h0101, 16'h0);
        push(2, 1'b0, 16'h0202, 16'h0);
        cycle();
        chk("all3_first", {29'd0, blit_gnt, host_gnt, vid_gnt}, 32'b001);
        run_until_idle(100);

        // Reset while a host read is on the bus
        push(1, 1'b0, 16'h0042, 16'h0);
        cycle();
        chk("abort_gnt", {31'd0, host_gnt}, 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_rdv", {31'd0, host_rd_valid}, 32'd0);
        chk("abort_sel", {31'd0, vram_sel}, 32'd0);
        chk("abort_addr", {16'd0, vram_addr}, 32'd0);
        chk("abort_rd_data", {16'd0, rd_data}, 32'd0);
        push(1, 1'b1, 16'h0500, 16'h1111);
        push(2, 1'b1, 16'h0600, 16'h2222);
        cycle();
        chk("post_rst_tie", {30'd0, blit_gnt, host_gnt}, 32'b01);
        run_until_idle(100);

        // Write to 0x00FF then stay idle
        push(1, 1'b1, 16'h00FF, 16'h5A5A);
        run_until_idle(100);
        repeat (10) begin
            cycle();
            chk("idle_sel", {30'd0, vram_sel, vram_wr}, 32'd0);
            chk("idle_addr", {16'd0, vram_addr}, 32'h00FF);
        end

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (q[r].size() < 2 && $urandom_range(0, 2) == 0)
                    push(r, 1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom));
            end
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        run_until_idle(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
